// File: rtl/sram_arb_2p_if.sv
// Single-word request/response channel between one requester and sram_arb_2p.
// The requester drives req_* (master); the arbiter returns ready and read data (slave).
interface sram_arb_2p_if #(
    parameter int unsigned AW = 13,
    parameter int unsigned DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_arb_2p.sv
// Two-port round-robin arbiter with burst ownership in front of a 1-cycle-read SRAM macro.
// Optional SRAM_ARB_PERF_EN adds per-port stall counters and a clr_stats_i clear input.
module sram_arb_2p #(
    parameter int unsigned AW        = 13,
    parameter int unsigned DW        = 32,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    sram_arb_2p_if.slave  p0,
    sram_arb_2p_if.slave  p1,
    output logic          sram_csbn_o,
    output logic          sram_wsbn_o,
    output logic [AW-1:0] sram_waddr_o,
    output logic [AW-1:0] sram_raddr_o,
    output logic [DW-1:0] sram_wdata_o,
    input  logic [DW-1:0] sram_rdata_i
`ifdef SRAM_ARB_PERF_EN
    ,
    input  logic          clr_stats_i,
    output logic [31:0]   p0_stall_cnt_o,
    output logic [31:0]   p1_stall_cnt_o
`endif
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] BMAX = CW'(BURST_MAX);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          rr_q, rr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          pend_id_q, pend_id_d;
    logic [AW-1:0] waddr_q, raddr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata0_q, rdata1_q;

    logic [1:0]    vld;
    logic          own;
    logic          gnt_vld;
    logic          gnt_id;
    logic          gnt;
    logic          gnt_we;
    logic [AW-1:0] gnt_addr;
    logic [DW-1:0] gnt_wdata;
    logic          rsp0_hit, rsp1_hit;

    assign vld = {p1.req_valid, p0.req_valid};
    assign own = (state_q == ST_OWN1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Grant selection and ownership transitions
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (vld != 2'b00) begin
                gnt_vld = 1'b1;
                gnt_id  = (vld == 2'b11) ? rr_q : vld[1];
                state_d = gnt_id ? ST_OWN1 : ST_OWN0;
                cnt_d   = CW'(1);
            end
        end else if (vld[own] && (cnt_q < BMAX)) begin
            gnt_vld = 1'b1;
            gnt_id  = own;
            cnt_d   = cnt_q + CW'(1);
        end else begin
            // Owner dropped or exhausted its burst: hand over to the peer without a bubble
            rr_d = ~own;
            if (vld[~own]) begin
                gnt_vld = 1'b1;
                gnt_id  = ~own;
                state_d = own ? ST_OWN0 : ST_OWN1;
                cnt_d   = CW'(1);
            end else begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end
    end

    assign gnt       = gnt_vld & ~rst;
    assign gnt_we    = gnt_id ? p1.req_we    : p0.req_we;
    assign gnt_addr  = gnt_id ? p1.req_addr  : p0.req_addr;
    assign gnt_wdata = gnt_id ? p1.req_wdata : p0.req_wdata;

    assign p0.req_ready = gnt & ~gnt_id;
    assign p1.req_ready = gnt &  gnt_id;

    // SRAM drive; address/data buses park on their last value when idle
    assign sram_csbn_o  = ~gnt;
    assign sram_wsbn_o  = ~(gnt & gnt_we);
    assign sram_raddr_o = gnt ? gnt_addr : raddr_q;
    assign sram_waddr_o = (gnt & gnt_we) ? gnt_addr  : waddr_q;
    assign sram_wdata_o = (gnt & gnt_we) ? gnt_wdata : wdata_q;

    assign pend_d    = gnt & ~gnt_we;
    assign pend_id_d = gnt ? gnt_id : pend_id_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waddr_q   <= '0;
            raddr_q   <= '0;
            wdata_q   <= '0;
            pend_q    <= 1'b0;
            pend_id_q <= 1'b0;
        end else begin
            waddr_q   <= sram_waddr_o;
            raddr_q   <= sram_raddr_o;
            wdata_q   <= sram_wdata_o;
            pend_q    <= pend_d;
            pend_id_q <= pend_id_d;
        end
    end

    // Read data passes straight through in the response cycle and is held afterwards
    assign rsp0_hit = pend_q & ~pend_id_q;
    assign rsp1_hit = pend_q &  pend_id_q;

    assign p0.rsp_valid = rsp0_hit & ~rst;
    assign p1.rsp_valid = rsp1_hit & ~rst;
    assign p0.rsp_rdata = rsp0_hit ? sram_rdata_i : rdata0_q;
    assign p1.rsp_rdata = rsp1_hit ? sram_rdata_i : rdata1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rdata0_q <= p0.rsp_rdata;
            rdata1_q <= p1.rsp_rdata;
        end
    end

`ifdef SRAM_ARB_PERF_EN
    logic [31:0] stall0_q, stall1_q;

    // Saturating count of cycles a requester waits with valid high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall0_q <= '0;
            stall1_q <= '0;
        end else if (clr_stats_i) begin
            stall0_q <= '0;
            stall1_q <= '0;
        end else begin
            if (p0.req_valid && !p0.req_ready && (stall0_q != 32'hFFFF_FFFF))
                stall0_q <= stall0_q + 32'd1;
            if (p1.req_valid && !p1.req_ready && (stall1_q != 32'hFFFF_FFFF))
                stall1_q <= stall1_q + 32'd1;
        end
    end

    assign p0_stall_cnt_o = stall0_q;
    assign p1_stall_cnt_o = stall1_q;
`endif

endmodule

// File: tb/tb_sram_arb_2p.sv
// Bench for sram_arb_2p: directed scenarios followed by random traffic, checked
// against a transaction-level arbitration/memory model and a behavioural SRAM.
module tb_sram_arb_2p;
    localparam int unsigned AW        = 13;
    localparam int unsigned DW        = 32;
    localparam int unsigned BURST_MAX = 4;
    localparam int unsigned DEPTH     = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          sram_csbn, sram_wsbn;
    logic [AW-1:0] sram_waddr, sram_raddr;
    logic [DW-1:0] sram_wdata, sram_rdata;

    sram_arb_2p_if #(.AW(AW), .DW(DW)) p0_bus ();
    sram_arb_2p_if #(.AW(AW), .DW(DW)) p1_bus ();

`ifdef SRAM_ARB_PERF_EN
    logic [31:0] p0_stall, p1_stall;
`endif

    sram_arb_2p #(.AW(AW), .DW(DW), .BURST_MAX(BURST_MAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .p0           (p0_bus),
        .p1           (p1_bus),
        .sram_csbn_o  (sram_csbn),
        .sram_wsbn_o  (sram_wsbn),
        .sram_waddr_o (sram_waddr),
        .sram_raddr_o (sram_raddr),
        .sram_wdata_o (sram_wdata),
        .sram_rdata_i (sram_rdata)
`ifdef SRAM_ARB_PERF_EN
        ,
        .clr_stats_i    (1'b0),
        .p0_stall_cnt_o (p0_stall),
        .p1_stall_cnt_o (p1_stall)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int i);
        return 32'hA500_0000 ^ (DW'(i) * 32'h0000_9E37);
    endfunction

    // Behavioural SRAM macro: active-low enables, read data one cycle after access
    logic [DW-1:0] mem [DEPTH];
    bit            mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] = init_word(i);
            mem_ready = 1'b1;
        end
        if (!sram_csbn) begin
            if (!sram_wsbn) mem[sram_waddr] = sram_wdata;
            else            sram_rdata <= mem[sram_raddr];
        end
    end

    // Reference model: who owns the array, how long, and whose turn is next
    int            m_owner, m_run, m_rr;
    int            exp_rsp_port;
    logic [DW-1:0] exp_rsp_data;
    logic [DW-1:0] last_rdata [2];
    logic [AW-1:0] h_waddr, h_raddr;
    logic [DW-1:0] h_wdata;
    logic [DW-1:0] ref_mem [DEPTH];

    int            checks, errors;
    int            obs_g;
    bit            obs_csbn, obs_wsbn;
    logic          obs_rsp_v [2];
    logic [DW-1:0] obs_rsp_d [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1; m_run = 0; m_rr = 0;
        exp_rsp_port = -1; exp_rsp_data = '0;
        last_rdata[0] = '0; last_rdata[1] = '0;
        h_waddr = '0; h_raddr = '0; h_wdata = '0;
    endfunction

    function automatic int model_grant(input bit v0, input bit v1);
        bit v [2];
        v[0] = v0; v[1] = v1;
        if (m_owner < 0) begin
            if (v0 && v1) return m_rr;
            if (v0) return 0;
            if (v1) return 1;
            return -1;
        end
        if (v[m_owner] && m_run < int'(BURST_MAX)) return m_owner;
        if (v[1 - m_owner]) return 1 - m_owner;
        return -1;
    endfunction

    function automatic void model_commit(input int g);
        if (m_owner >= 0 && g != m_owner) m_rr = 1 - m_owner;
        if (g < 0) begin
            m_owner = -1; m_run = 0;
        end else if (g == m_owner) begin
            m_run++;
        end else begin
            m_owner = g; m_run = 1;
        end
    endfunction

    task automatic set_req(input int n, input bit v, input bit we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (n == 0) begin
            p0_bus.req_valid = v; p0_bus.req_we = we; p0_bus.req_addr = a; p0_bus.req_wdata = d;
        end else begin
            p1_bus.req_valid = v; p1_bus.req_we = we; p1_bus.req_addr = a; p1_bus.req_wdata = d;
        end
    endtask

    // One clock: sample at the falling edge, compare with the model, advance the model
    task automatic cycle();
        int            g;
        bit            we;
        logic [AW-1:0] a, ew, er;
        logic [DW-1:0] d, ed, edat;
        bit            ev;
        @(negedge clk);
        if (rst) model_reset();
        g = rst ? -1 : model_grant(p0_bus.req_valid, p1_bus.req_valid);
        obs_g = p0_bus.req_ready ? (p1_bus.req_ready ? 2 : 0) : (p1_bus.req_ready ? 1 : -1);
        obs_csbn = sram_csbn;
        obs_wsbn = sram_wsbn;
        obs_rsp_v[0] = p0_bus.rsp_valid; obs_rsp_d[0] = p0_bus.rsp_rdata;
        obs_rsp_v[1] = p1_bus.rsp_valid; obs_rsp_d[1] = p1_bus.rsp_rdata;
        we = 1'b0; a = '0; d = '0;
        if (g == 0) begin we = p0_bus.req_we; a = p0_bus.req_addr; d = p0_bus.req_wdata; end
        if (g == 1) begin we = p1_bus.req_we; a = p1_bus.req_addr; d = p1_bus.req_wdata; end
        ew = h_waddr; er = h_raddr; ed = h_wdata;
        if (g >= 0) begin
            er = a;
            if (we) begin ew = a; ed = d; end
        end
        check("grant", 64'(obs_g), 64'(g));
        check("csbn", 64'(sram_csbn), 64'(g < 0));
        check("wsbn", 64'(sram_wsbn), 64'(!(g >= 0 && we)));
        check("raddr", 64'(sram_raddr), 64'(er));
        check("waddr", 64'(sram_waddr), 64'(ew));
        check("wdata", 64'(sram_wdata), 64'(ed));
        for (int n = 0; n < 2; n++) begin
            ev   = (exp_rsp_port == n);
            edat = ev ? exp_rsp_data : last_rdata[n];
            check($sformatf("p%0d_rsp_valid", n), 64'(obs_rsp_v[n]), 64'(ev));
            check($sformatf("p%0d_rsp_rdata", n), 64'(obs_rsp_d[n]), 64'(edat));
        end
        if (exp_rsp_port >= 0) last_rdata[exp_rsp_port] = exp_rsp_data;
        exp_rsp_port = -1;
        if (g >= 0) begin
            if (we) ref_mem[a] = d;
            else begin exp_rsp_port = g; exp_rsp_data = ref_mem[a]; end
        end
        h_waddr = ew; h_raddr = er; h_wdata = ed;
        if (!rst) model_commit(g);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit            rv;
        bit            rwe;
        logic [AW-1:0] ra;
        checks = 0;
        errors = 0;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_word(i);
        model_reset();

        // Reset with both requesters pushing
        rst = 1'b1;
        set_req(0, 1'b1, 1'b0, 13'h0005, '0);
        set_req(1, 1'b1, 1'b0, 13'h0006, '0);
        cycle();
        cycle();
        check("reset_ready", 64'(obs_g), 64'(-1));
        check("reset_csbn", 64'(obs_csbn), 64'd1);
        check("reset_wsbn", 64'(obs_wsbn), 64'd1);
        rst = 1'b0;
        cycle();
        check("first_grant_p0", 64'(obs_g), 64'd0);
        set_req(0, 1'b0, 1'b0, 13'h0005, '0);
        set_req(1, 1'b0, 1'b0, 13'h0006, '0);
        cycle();
        cycle();

        // Single write then read from p0
        set_req(0, 1'b1, 1'b1, 13'h0010, 32'hDEAD_BEEF);
        cycle();
        check("wr_grant", 64'(obs_g), 64'd0);
        check("wr_wsbn", 64'(obs_wsbn), 64'd0);
        set_req(0, 1'b1, 1'b0, 13'h0010, '0);
        cycle();
        check("rd_wsbn", 64'(obs_wsbn), 64'd1);
        set_req(0, 1'b0, 1'b0, 13'h0010, '0);
        cycle();
        check("rd_rsp_valid", 64'(obs_rsp_v[0]), 64'd1);
        check("rd_rsp_data", 64'(obs_rsp_d[0]), 64'hDEAD_BEEF);
        check("rd_p1_quiet", 64'(obs_rsp_v[1]), 64'd0);
        cycle();
        check("rsp_single_pulse", 64'(obs_rsp_v[0]), 64'd0);
        check("rsp_data_hold", 64'(obs_rsp_d[0]), 64'hDEAD_BEEF);

        // Burst limit with both requesters saturating
        rst = 1'b1; cycle(); rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 13'h0020, '0);
        set_req(1, 1'b1, 1'b0, 13'h0021, '0);
        for (int i = 0; i < 12; i++) begin
            cycle();
            check($sformatf("burst_grant_%0d", i), 64'(obs_g), 64'((i / 4) % 2));
            check($sformatf("burst_csbn_%0d", i), 64'(obs_csbn), 64'd0);
        end
        set_req(0, 1'b0, 1'b0, 13'h0020, '0);
        set_req(1, 1'b0, 1'b0, 13'h0021, '0);
        cycle();

        // Owner drops valid mid-burst; the peer takes over in the same cycle
        rst = 1'b1; cycle(); rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 13'h0030, '0);
        set_req(1, 1'b1, 1'b0, 13'h0031, '0);
        cycle(); check("drop_g0", 64'(obs_g), 64'd0);
        cycle(); check("drop_g1", 64'(obs_g), 64'd0);
        set_req(0, 1'b0, 1'b0, 13'h0030, '0);
        cycle(); check("drop_handover", 64'(obs_g), 64'd1);
        cycle(); cycle(); cycle();
        check("drop_p1_last", 64'(obs_g), 64'd1);
        cycle(); check("drop_release_idle", 64'(obs_g), 64'(-1));
        set_req(0, 1'b1, 1'b0, 13'h0030, '0);
        cycle(); check("drop_rr_back_to_p0", 64'(obs_g), 64'd0);
        set_req(0, 1'b0, 1'b0, 13'h0030, '0);
        set_req(1, 1'b0, 1'b0, 13'h0031, '0);
        cycle();

        // Response routing: preload through both ports, then back-to-back reads
        rst = 1'b1; cycle(); rst = 1'b0;
        set_req(0, 1'b1, 1'b1, 13'h1FFF, 32'h0000_0001);
        cycle();
        set_req(0, 1'b0, 1'b0, 13'h1FFF, '0);
        set_req(1, 1'b1, 1'b1, 13'h0000, 32'h0000_0002);
        cycle();
        set_req(1, 1'b0, 1'b0, 13'h0000, '0);
        cycle();
        set_req(0, 1'b1, 1'b0, 13'h1FFF, '0);
        set_req(1, 1'b1, 1'b0, 13'h0000, '0);
        cycle(); check("route_g0", 64'(obs_g), 64'd0);
        set_req(0, 1'b0, 1'b0, 13'h1FFF, '0);
        cycle();
        check("route_g1", 64'(obs_g), 64'd1);
        check("route_p0_valid", 64'(obs_rsp_v[0]), 64'd1);
        check("route_p0_data", 64'(obs_rsp_d[0]), 64'h1);
        set_req(1, 1'b0, 1'b0, 13'h0000, '0);
        cycle();
        check("route_p1_valid", 64'(obs_rsp_v[1]), 64'd1);
        check("route_p1_data", 64'(obs_rsp_d[1]), 64'h2);
        check("route_p0_quiet", 64'(obs_rsp_v[0]), 64'd0);

        // Reset lands in the response cycle of a p1 read
        set_req(1, 1'b1, 1'b0, 13'h0010, '0);
        cycle(); check("midrst_p1_grant", 64'(obs_g), 64'd1);
        set_req(1, 1'b0, 1'b0, 13'h0010, '0);
        rst = 1'b1;
        cycle();
        check("midrst_rsp_dropped", 64'(obs_rsp_v[1]), 64'd0);
        rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 13'h0011, '0);
        set_req(1, 1'b1, 1'b0, 13'h0012, '0);
        cycle(); check("midrst_first_p0", 64'(obs_g), 64'd0);
        set_req(0, 1'b0, 1'b0, 13'h0011, '0);
        set_req(1, 1'b0, 1'b0, 13'h0012, '0);
        cycle();
        cycle();

        // Random traffic on a small address window to provoke hazards
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int n = 0; n < 2; n++) begin
                rv = (n == 0) ? p0_bus.req_valid : p1_bus.req_valid;
                if (!rv || obs_g == n) begin
                    rv  = ($urandom_range(0, 3) != 0);
                    rwe = ($urandom_range(0, 2) == 0);
                    ra  = ($urandom_range(0, 7) == 0) ? AW'(DEPTH - 1) : AW'($urandom_range(0, 15));
                    set_req(n, rv, rwe, ra, $urandom);
                end
            end
            cycle();
        end
        rst = 1'b0;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_arb_2p.md
Name: sram_arb_2p

Overview:
- Two-requester arbiter and sequencer for one 8K x 32 synchronous SRAM macro with active-low enables and 1-cycle registered read.
- Each requester issues single-word read/write requests over valid/ready; the block grants at most one access per cycle and returns read data with a response strobe.
- Round-robin fairness with optional burst ownership, so a streaming requester (DMA) can hold the array for up to BURST_MAX consecutive accesses.
- Sits between core/DMA masters and the SRAM instance.

Parameters:
- AW, 13, word address width (8192 words).
- DW, 32, data width.
- BURST_MAX, 4, max consecutive grants to one owner before forced release; legal range 1..15 (1 = pure round-robin).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous reset, active-high
- pN_req_valid  in  1  request valid, N = 0,1
- pN_req_ready  out  1  request accepted this cycle
- pN_req_we  in  1  1 = write, 0 = read
- pN_req_addr  in  AW  word address
- pN_req_wdata  in  DW  write data
- pN_rsp_valid  out  1  read data valid; no backpressure
- pN_rsp_rdata  out  DW  read data
- sram_csbn  out  1  SRAM enable, active low
- sram_wsbn  out  1  SRAM write enable, active low
- sram_waddr  out  AW  SRAM write address
- sram_raddr  out  AW  SRAM read address
- sram_wdata  out  DW  SRAM write data
- sram_rdata  in  DW  SRAM read data, valid the cycle after a read access

Behaviour:
- Clock is clk. Reset is rst: one clock domain, asynchronous assert, active-high.
- Reset values: state IDLE, rr_ptr = 0, burst_cnt = 0, rsp_pend = 0. Outputs: pN_req_ready = 0, pN_rsp_valid = 0, pN_rsp_rdata = 0, sram_csbn = 1, sram_wsbn = 1.
- While rst is high, ready is forced 0 and csbn/wsbn forced 1 regardless of inputs.
- States:
  - IDLE: no owner. If exactly one requester is valid, grant it. If both are valid, grant the port at rr_ptr. The granted port moves to OWN0 or OWN1 with burst_cnt = 1.
  - OWNn: grant port n while pn_req_valid = 1 and burst_cnt < BURST_MAX; increment burst_cnt on each grant.
- Owner release:
  - Owner drops valid: go to IDLE. A waiting peer is granted in the same cycle (no bubble).
  - burst_cnt reaches BURST_MAX: owner is not granted that cycle. The peer is granted if valid; otherwise go to IDLE. Set rr_ptr to the non-owner.
  - On every release, rr_ptr points away from the released owner.
- Grant is combinational from state and valids. pN_req_ready = grant. A transfer occurs when valid and ready are both high.
- SRAM drive (combinational):
  - Grant with we = 1: csbn = 0, wsbn = 0, waddr = raddr = addr, wdata = req_wdata.
  - Grant with we = 0: csbn = 0, wsbn = 1, raddr = addr.
  - No grant: csbn = 1, wsbn = 1; address and data hold their previous values (no toggling).
- Read response:
  - A read grant registers rsp_pend = 1 and rsp_id = n.
  - Next cycle: pn_rsp_valid = 1 and pn_rsp_rdata = sram_rdata, for exactly one cycle. Latency is fixed at 1 cycle after the accept.
  - Writes produce no response; the SRAM read-during-write data is discarded.
- Back-to-back: one access per cycle, full throughput. A write then a read to the same address in consecutive cycles returns the new data.
- Reset mid-operation: a pending response is dropped (no rsp_valid after rst deasserts); ownership and rr_ptr are cleared.
- Requesters must hold addr/we/wdata stable while valid and not ready.
- pN_rsp_rdata holds its last value when rsp_valid = 0.

Optional Feature:
- SRAM_ARB_PERF_EN defined adds ports pN_stall_cnt (out, 32): counts cycles with valid = 1 and ready = 0, saturating at 0xFFFFFFFF, reset to 0 by rst. Also adds clr_stats (in, 1): synchronous clear of both counters.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: rst = 1 with both valids high -> ready = 0, csbn = 1, wsbn = 1. Release rst -> p0 granted first (rr_ptr = 0).
- Single write/read: p0 writes 0xDEADBEEF to addr 0x0010, then reads 0x0010 -> sram_wsbn low for 1 cycle; p0_rsp_valid 1 cycle after the read accept; rdata = 0xDEADBEEF; p1_rsp_valid stays 0.
- Burst limit: BURST_MAX = 4, both valid continuously -> grant pattern p0×4, p1×4, p0×4…; csbn low every cycle, no idle cycles.
- Release on drop: p0 valid 2 cycles, p1 valid throughout -> p0, p0, then p1 in the cycle p0 drops valid; rr_ptr = 0 after p1's burst.
- Response routing: p0 reads 0x1FFF (preloaded 0x1), p1 reads 0x0000 (preloaded 0x2) back-to-back -> p0_rsp 0x1 then p1_rsp 0x2 on consecutive cycles.
- Mid-op reset: assert rst in the cycle after a p1 read accept -> p1_rsp_valid never pulses; after release the first grant goes to p0.
